// File: rtl/usb_fs_line_rx.sv
// Full-speed USB receive front end: synchronizes D+/D-, recovers bit timing from
// line transitions, NRZI-decodes, removes stuff bits and frames packets.
module usb_fs_line_rx #(
    parameter int unsigned BUS_RESET_CYCLES = 480
) (
    input  logic clk_48mhz,
    input  logic reset,
    input  logic usb_p_rx,
    input  logic usb_n_rx,
    output logic pkt_start,
    output logic bit_strobe,
    output logic bit_data,
    output logic pkt_end,
    output logic stuff_err,
    output logic bus_reset
);
    localparam int unsigned BRW = $clog2(BUS_RESET_CYCLES + 1);
    localparam logic [BRW-1:0] BR_MAX = BRW'(BUS_RESET_CYCLES);

    typedef enum logic [1:0] {LS_J, LS_K, LS_SE0} line_e;
    typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_DATA, ST_EOP} state_e;

    logic           p_meta_q, p_sync_q, n_meta_q, n_sync_q;
    line_e          line_q, line_d;
    line_e          prev_q, prev_d;
    logic [1:0]     phase_q, phase_d;
    state_e         state_q, state_d;
    logic [2:0]     zeros_q, zeros_d;
    logic [2:0]     ones_q, ones_d;
    logic [BRW-1:0] br_cnt_q, br_cnt_d;
    logic           bus_reset_q, bus_reset_d;
    logic           start_q, start_d, strobe_q, strobe_d, data_q, data_d;
    logic           end_q, end_d, err_q, err_d;
    logic           sample, nrzi_bit;

    // SE1 carries no information, so it keeps the previous line state
    always_comb begin
        unique case ({p_sync_q, n_sync_q})
            2'b10:   line_d = LS_J;
            2'b01:   line_d = LS_K;
            2'b00:   line_d = LS_SE0;
            default: line_d = line_q;
        endcase
        phase_d = (line_d != line_q) ? '0 : phase_q + 2'd1;
    end

    assign sample   = (phase_q == 2'd2);
    assign nrzi_bit = (line_q == prev_q);

    always_comb begin
        if (p_sync_q || n_sync_q)
            br_cnt_d = '0;
        else if (br_cnt_q == BR_MAX)
            br_cnt_d = br_cnt_q;
        else
            br_cnt_d = br_cnt_q + BRW'(1);
        bus_reset_d = (br_cnt_d == BR_MAX);
    end

    always_comb begin
        state_d  = state_q;
        zeros_d  = zeros_q;
        ones_d   = ones_q;
        prev_d   = prev_q;
        start_d  = 1'b0;
        strobe_d = 1'b0;
        data_d   = 1'b0;
        end_d    = 1'b0;
        err_d    = 1'b0;
        if (sample && line_q != LS_SE0)
            prev_d = line_q;
        if (sample) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (line_q == LS_K) begin
                        state_d = ST_SYNC;
                        zeros_d = '0;
                    end
                end
                ST_SYNC: begin
                    if (line_q == LS_SE0)
                        state_d = ST_IDLE;
                    else if (!nrzi_bit)
                        zeros_d = (zeros_q == 3'd7) ? zeros_q : zeros_q + 3'd1;
                    else if (zeros_q >= 3'd5) begin
                        start_d = 1'b1;
                        ones_d  = '0;
                        state_d = ST_DATA;
                    end else
                        state_d = ST_IDLE;
                end
                ST_DATA: begin
                    if (line_q == LS_SE0)
                        state_d = ST_EOP;
                    else if (ones_q == 3'd6) begin
                        if (nrzi_bit) begin
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                        end else
                            ones_d = '0;
                    end else begin
                        strobe_d = 1'b1;
                        data_d   = nrzi_bit;
                        ones_d   = nrzi_bit ? ones_q + 3'd1 : '0;
                    end
                end
                ST_EOP: begin
                    unique case (line_q)
                        LS_SE0: state_d = ST_EOP;
                        LS_J: begin
                            end_d   = 1'b1;
                            state_d = ST_IDLE;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
                default: state_d = ST_IDLE;
            endcase
        end
        // A bus reset wins over anything the packet framer was doing
        if (bus_reset_q) begin
            state_d  = ST_IDLE;
            start_d  = 1'b0;
            strobe_d = 1'b0;
            data_d   = 1'b0;
            end_d    = 1'b0;
            err_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            p_meta_q    <= 1'b1;
            p_sync_q    <= 1'b1;
            n_meta_q    <= 1'b0;
            n_sync_q    <= 1'b0;
            line_q      <= LS_J;
            prev_q      <= LS_J;
            phase_q     <= '0;
            state_q     <= ST_IDLE;
            zeros_q     <= '0;
            ones_q      <= '0;
            br_cnt_q    <= '0;
            bus_reset_q <= 1'b0;
            start_q     <= 1'b0;
            strobe_q    <= 1'b0;
            data_q      <= 1'b0;
            end_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            p_meta_q    <= usb_p_rx;
            p_sync_q    <= p_meta_q;
            n_meta_q    <= usb_n_rx;
            n_sync_q    <= n_meta_q;
            line_q      <= line_d;
            prev_q      <= prev_d;
            phase_q     <= phase_d;
            state_q     <= state_d;
            zeros_q     <= zeros_d;
            ones_q      <= ones_d;
            br_cnt_q    <= br_cnt_d;
            bus_reset_q <= bus_reset_d;
            start_q     <= start_d;
            strobe_q    <= strobe_d;
            data_q      <= data_d;
            end_q       <= end_d;
            err_q       <= err_d;
        end
    end

    assign pkt_start  = start_q;
    assign bit_strobe = strobe_q;
    assign bit_data   = data_q;
    assign pkt_end    = end_q;
    assign stuff_err  = err_q;
    assign bus_reset  = bus_reset_q;
endmodule
